arb_client: RTL and testbench
=============================

Name: arb_client

Overview:
- Master-side agent for the shared-resource arbiter; one instance sits in front of each master.
- Accepts a transfer command from local logic over a valid/ready handshake.
- Drives the arbiter's req and pri lines for its slot and tracks the registered grant returned by the arbiter.
- Counts granted beats, releases the request when the transfer completes, and aborts on a grant-wait timeout.

Parameters:
- MAX_BEATS, 16, maximum beats per command.
- TIMEOUT, 8, consecutive ungranted REQ cycles before abort; 0 disables timeout.
- LEN_W, $clog2(MAX_BEATS+1), width of the command length field.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset: asynchronous, active-low; asserted when 0.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_len  input  LEN_W  beats requested. 0 is treated as 1. Values above MAX_BEATS saturate to MAX_BEATS.
- cmd_urgent  input  1  request high priority for this command.
- req  output  1  to arbiter req[k].
- pri  output  1  to arbiter pri[k].
- grant  input  1  from arbiter grant[k]; registered by the arbiter, so it lags req by one cycle.
- beat  output  1  this cycle is an owned transfer cycle.
- done  output  1  single-cycle pulse on the final beat.
- timeout  output  1  single-cycle pulse on abort.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, REQ, OWN, RELEASE. State, remaining counter (LEN_W), wait counter and urgent_q are registered.
- Reset (rst=0) takes effect immediately, asynchronously:
  - state=IDLE, counters=0, urgent_q=0.
  - Therefore req=0, pri=0, beat=0, done=0, timeout=0, busy=0, cmd_ready=1.
- Reset mid-transfer drops req at once; no done or timeout pulse is issued.
- cmd_ready = (state==IDLE).
- A command is accepted on a clock edge with cmd_valid && cmd_ready. On acceptance:
  - latch the length (0→1, saturated to MAX_BEATS) and urgent_q.
  - clear the wait counter.
  - go to REQ.
- req = (state==REQ || state==OWN). pri = req && urgent_q. All outputs are combinational from registered state plus grant.
- beat = req && grant. done = beat && remaining==1.
- REQ:
  - grant=1: beat. If remaining==1 → RELEASE; otherwise remaining-1 → OWN.
  - grant=0: wait counter +1. If TIMEOUT!=0 and wait counter==TIMEOUT-1, assert timeout this cycle and go to IDLE (remaining discarded). Otherwise stay in REQ.
- OWN:
  - grant=1: beat, remaining-1. If remaining==1, assert done and go to RELEASE.
  - grant=0 (preempted by a higher-priority master): go to REQ, clear wait counter, keep remaining. No beat this cycle.
- RELEASE:
  - req=0. Lasts exactly one cycle, then IDLE.
  - grant may still read 1 in this cycle because of the arbiter's register lag. It is ignored: no beat, no done.
- Minimum command-to-command latency: accept edge → REQ → grant one cycle later → beats → RELEASE → IDLE.
  - For len=1 with immediate grant, cmd_ready returns 4 cycles after acceptance.
- Counters never wrap:
  - wait counter is held at TIMEOUT-1 maximum; when TIMEOUT=0 it saturates at all-ones.
  - remaining never decrements below 1.
- Simultaneous events:
  - A command offered in RELEASE is not accepted (cmd_ready=0).
  - A grant arriving in the same cycle the timeout condition is reached wins: the beat counts, no timeout.
- cmd_len and cmd_urgent are sampled only at acceptance. Later changes have no effect on the in-flight command.

Test Plan:
- Basic flow: len=3, urgent=0, grant asserted the cycle after req and held → req high for 4 cycles, beat on cycles 2–4 after acceptance, done on the third beat, req=0 in RELEASE while grant=1 with no beat, cmd_ready=1 the cycle after.
- Zero length: len=0 → exactly one beat and done together, then RELEASE, IDLE.
- Timeout: TIMEOUT=8, grant never asserted → timeout pulse in the 8th REQ cycle, req drops next cycle, cmd_ready=1. A grant arriving in that 8th cycle instead gives a beat and no timeout.
- Preemption: len=4, grant high for 2 beats, low 3 cycles, high again → exactly 4 beats total, done on the 4th, no timeout, req held throughout the gap.
- Priority: urgent=1 → pri=req in every cycle. Command accepted while busy is refused, and cmd_urgent changes after acceptance do not change pri.
- Async reset: rst=0 mid-OWN, between clock edges → req, pri, beat, busy fall immediately. After release, cmd_ready=1 and a new len=2 command completes normally.

Source files
------------

// File: rtl/arb_client.sv
// Master-side agent for the shared-resource arbiter: takes one command at a time,
// drives req/pri for its slot, counts granted beats and aborts on a grant-wait timeout.
module arb_client #(
  parameter int MAX_BEATS = 16,
  parameter int TIMEOUT   = 8,
  parameter int LEN_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_urgent,
  output logic             req,
  output logic             pri,
  input  logic             grant,
  output logic             beat,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // With the timeout disabled the wait counter simply parks at all-ones.
  localparam logic [WAIT_W-1:0] WAIT_MAX = (TIMEOUT == 0) ? {WAIT_W{1'b1}} : WAIT_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_BEATS);
  localparam logic [LEN_W-1:0]  ONE      = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, OWN, RELEASE} state_t;

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              urgent_reg, urgent_next;
  logic [LEN_W-1:0]  len_eff;
  logic              wait_hit;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0)
      len_eff = ONE;
    else if (cmd_len > MAX_LEN)
      len_eff = MAX_LEN;
  end

  assign wait_hit  = (TIMEOUT != 0) && (wait_reg == WAIT_MAX);

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign req       = (state_reg == REQ) || (state_reg == OWN);
  assign pri       = req && urgent_reg;
  assign beat      = req && grant;
  assign done      = beat && (remaining_reg == ONE);
  // A grant in the deadline cycle wins over the abort.
  assign timeout   = (state_reg == REQ) && !grant && wait_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      wait_reg      <= '0;
      urgent_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      wait_reg      <= wait_next;
      urgent_reg    <= urgent_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    wait_next      = wait_reg;
    urgent_next    = urgent_reg;
    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next     = REQ;
          remaining_next = len_eff;
          urgent_next    = cmd_urgent;
          wait_next      = '0;
        end
      end
      REQ: begin
        if (grant) begin
          if (remaining_reg == ONE) begin
            state_next = RELEASE;
          end else begin
            remaining_next = remaining_reg - ONE;
            state_next     = OWN;
          end
        end else if (wait_hit) begin
          state_next = IDLE;
        end else if (wait_reg != WAIT_MAX) begin
          wait_next = wait_reg + 1'b1;
        end
      end
      OWN: begin
        if (grant) begin
          if (remaining_reg == ONE)
            state_next = RELEASE;
          else
            remaining_next = remaining_reg - ONE;
        end else begin
          // Preempted: go back to requesting with a fresh wait budget.
          state_next = REQ;
          wait_next  = '0;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arb_client.sv
// Directed bench for arb_client: per-cycle vector table plus hand sequences for
// length saturation and asynchronous reset in the middle of a transfer.
module tb_arb_client;

  localparam int LEN_W = 5;

  // Output vector order: {cmd_ready, req, pri, beat, done, timeout, busy}
  localparam logic [6:0] IDLE_O = 7'b1000000;
  localparam logic [6:0] REQ_O  = 7'b0100001;
  localparam logic [6:0] BEAT_O = 7'b0101001;
  localparam logic [6:0] DONE_O = 7'b0101101;
  localparam logic [6:0] REL_O  = 7'b0000001;
  localparam logic [6:0] TO_O   = 7'b0100011;
  localparam logic [6:0] REQ_U  = 7'b0110001;
  localparam logic [6:0] BEAT_U = 7'b0111001;
  localparam logic [6:0] DONE_U = 7'b0111101;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_urgent = 1'b0;
  logic             grant = 1'b0;
  logic             cmd_ready, req, pri, beat, done, timeout, busy;

  typedef struct {
    int               tag;
    logic             valid;
    logic [LEN_W-1:0] len;
    logic             urgent;
    logic             grant;
    logic [6:0]       exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  arb_client #(.MAX_BEATS(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_urgent(cmd_urgent),
    .req(req), .pri(pri), .grant(grant),
    .beat(beat), .done(done), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic string tname(int t);
    case (t)
      0: return "basic";
      1: return "zero_len";
      2: return "priority";
      3: return "preempt";
      4: return "timeout";
      5: return "late_grant";
      6: return "saturate";
      7: return "async_reset";
      default: return "reset";
    endcase
  endfunction

  function automatic logic [6:0] outs();
    return {cmd_ready, req, pri, beat, done, timeout, busy};
  endfunction

  task automatic check(int tag, int idx, logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got rdy/req/pri/beat/done/to/busy=%b expected %b", tname(tag), idx, act, exp);
    end else begin
      $display("ok   %s[%0d]: %b", tname(tag), idx, act);
    end
  endtask

  task automatic check_int(int tag, string what, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tname(tag), what, act, exp);
    end else begin
      $display("ok   %s %s: %0d", tname(tag), what, act);
    end
  endtask

  task automatic add(int tag, logic v, int len, logic u, logic g, logic [6:0] e);
    vec_t r;
    r.tag = tag; r.valid = v; r.len = LEN_W'(len); r.urgent = u; r.grant = g; r.exp = e;
    vecs.push_back(r);
  endtask

  // One clock cycle: drive inputs after the falling edge, compare before the next rising edge.
  task automatic step(int tag, int idx, logic v, int len, logic u, logic g, logic [6:0] e);
    @(negedge clk);
    cmd_valid = v; cmd_len = LEN_W'(len); cmd_urgent = u; grant = g;
    #1;
    check(tag, idx, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit got_done;

    // Reset state, including a stray grant while in reset.
    #1 check(8, 0, IDLE_O);
    grant = 1'b1;
    #1 check(8, 1, IDLE_O);
    @(negedge clk);
    grant = 1'b0;
    rst = 1'b1;

    // Basic len=3; a command offered during RELEASE must be refused.
    add(0,1,3,0,0,IDLE_O); add(0,0,0,0,0,REQ_O); add(0,0,0,0,1,BEAT_O); add(0,0,0,0,1,BEAT_O);
    add(0,0,0,0,1,DONE_O); add(0,1,1,0,1,REL_O); add(0,0,0,0,0,IDLE_O);
    // len=0 behaves as one beat.
    add(1,1,0,0,0,IDLE_O); add(1,0,0,0,0,REQ_O); add(1,0,0,0,1,DONE_O); add(1,0,0,0,1,REL_O);
    add(1,0,0,0,0,IDLE_O);
    // Urgent command; offers while busy (non-urgent) are refused and do not alter pri.
    add(2,1,2,1,0,IDLE_O); add(2,1,5,0,0,REQ_U); add(2,1,5,0,1,BEAT_U); add(2,0,0,0,1,DONE_U);
    add(2,0,0,0,1,REL_O); add(2,0,0,0,0,IDLE_O);
    // len=4, two beats, three-cycle preemption gap, two more beats.
    add(3,1,4,0,0,IDLE_O); add(3,0,0,0,0,REQ_O); add(3,0,0,0,1,BEAT_O); add(3,0,0,0,1,BEAT_O);
    add(3,0,0,0,0,REQ_O); add(3,0,0,0,0,REQ_O); add(3,0,0,0,0,REQ_O); add(3,0,0,0,1,BEAT_O);
    add(3,0,0,0,1,DONE_O); add(3,0,0,0,1,REL_O); add(3,0,0,0,0,IDLE_O);
    // Never granted: pulse in the 8th REQ cycle, then idle.
    add(4,1,2,0,0,IDLE_O);
    for (int i = 0; i < 7; i++) add(4,0,0,0,0,REQ_O);
    add(4,0,0,0,0,TO_O); add(4,0,0,0,0,IDLE_O);
    // Grant arrives exactly in the 8th REQ cycle: beat wins over timeout.
    add(5,1,1,0,0,IDLE_O);
    for (int i = 0; i < 7; i++) add(5,0,0,0,0,REQ_O);
    add(5,0,0,0,1,DONE_O); add(5,0,0,0,0,REL_O); add(5,0,0,0,0,IDLE_O);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].tag, i, vecs[i].valid, int'(vecs[i].len), vecs[i].urgent, vecs[i].grant, vecs[i].exp);

    // Oversized length saturates to 16 beats.
    step(6, 0, 1'b1, 31, 1'b0, 1'b0, IDLE_O);
    nb = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      grant = (i > 0);
      #1;
      if (beat) nb++;
      if (done) got_done = 1'b1;
    end
    check_int(6, "beats", nb, 16);
    check_int(6, "done_seen", int'(got_done), 1);
    step(6, 1, 1'b0, 0, 1'b0, 1'b1, REL_O);
    step(6, 2, 1'b0, 0, 1'b0, 1'b0, IDLE_O);

    // Asynchronous reset in the middle of OWN, then a normal len=2 command.
    step(7, 0, 1'b1, 4, 1'b1, 1'b0, IDLE_O);
    step(7, 1, 1'b0, 0, 1'b0, 1'b0, REQ_U);
    step(7, 2, 1'b0, 0, 1'b0, 1'b1, BEAT_U);
    step(7, 3, 1'b0, 0, 1'b0, 1'b1, BEAT_U);
    #2 rst = 1'b0;
    #1 check(7, 4, IDLE_O);
    @(negedge clk);
    grant = 1'b0;
    #1 check(7, 5, IDLE_O);
    rst = 1'b1;
    step(7, 6, 1'b1, 2, 1'b0, 1'b0, IDLE_O);
    step(7, 7, 1'b0, 0, 1'b0, 1'b0, REQ_O);
    step(7, 8, 1'b0, 0, 1'b0, 1'b1, BEAT_O);
    step(7, 9, 1'b0, 0, 1'b0, 1'b1, DONE_O);
    step(7, 10, 1'b0, 0, 1'b0, 1'b1, REL_O);
    step(7, 11, 1'b0, 0, 1'b0, 1'b0, IDLE_O);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
